fb_rect_fill: RTL and testbench

Rectangle fill engine sitting directly upstream of the 800x480 1-bit frame buffer. On a start pulse it latches a rectangle and a colour, clips it to the screen, and writes every covered pixel into the frame buffer through the buffer's write port, one pixel per granted cycle in raster order. A `fb_ready` grant lets the arbiter give priority to VGA scanout reads.

---
 rtl/fb_rect_fill.sv | 183 ++++++++++++++++++
 tb/tb_fb_rect_fill.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_rect_fill.sv
// -----------------------------------------------------------------------------
// fb_rect_fill
//
// Rectangle fill engine placed directly in front of the 800x480 1-bit frame
// buffer. A start pulse latches a rectangle and a colour and clips it to the
// screen. The engine then writes every covered pixel through the buffer's write
// port in raster order, one pixel in each cycle where the arbiter grants
// fb_ready.
//
// Handshake: the engine offers a write in every FILL cycle. A write happens
// when load=1, and load is FILL & fb_ready. The buffer captures PIXEL_H,
// PIXEL_V and in on the same rising edge that samples load. When fb_ready=0
// the addresses and data are held, and the same pixel is offered again next
// cycle.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   start      one-cycle request, sampled only in IDLE
//   x0, y0     top-left corner (inclusive)
//   x1, y1     bottom-right corner (inclusive), clipped to the screen
//   color      fill value (1 = white, 0 = black)
//   fb_ready   write grant from the arbiter
//   busy       high while filling
//   done       one-cycle completion pulse (also for empty fills)
//   PIXEL_H    frame buffer column address
//   PIXEL_V    frame buffer row address
//   load       frame buffer write enable
//   in         frame buffer write data
//   state_o    current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module fb_rect_fill #(
   // Both resolutions must fit the 11-bit coordinate range.
   parameter int unsigned H_RES = 800,
   parameter int unsigned V_RES = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [10:0] x0,
   input  logic [10:0] y0,
   input  logic [10:0] x1,
   input  logic [10:0] y1,
   input  logic        color,
   input  logic        fb_ready,
   output logic        busy,
   output logic        done,
   output logic [10:0] PIXEL_H,
   output logic [10:0] PIXEL_V,
   output logic        load,
   output logic        in,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [10:0] H_LIM = 11'(H_RES);
   localparam logic [10:0] V_LIM = 11'(V_RES);
   localparam logic [10:0] H_MAX = 11'(H_RES - 1);
   localparam logic [10:0] V_MAX = 11'(V_RES - 1);

   state_t      state_q, state_d;
   logic [10:0] h_q, h_d;     // current column (drives PIXEL_H)
   logic [10:0] v_q, v_d;     // current row (drives PIXEL_V)
   logic [10:0] x0_q, x0_d;   // row restart column
   logic [10:0] y0_q, y0_d;
   logic [10:0] xe_q, xe_d;   // clipped right edge
   logic [10:0] ye_q, ye_d;   // clipped bottom edge
   logic        in_q, in_d;   // latched colour (drives in)

   // Clipping of the request as presented on the inputs.
   logic [10:0] xe_clip;
   logic [10:0] ye_clip;
   logic        rect_empty;

   always_comb begin
      xe_clip = (x1 > H_MAX) ? H_MAX : x1;
      ye_clip = (y1 > V_MAX) ? V_MAX : y1;
      // An off-screen x0/y0 is also caught by x0 > xe, but stating it
      // explicitly keeps the intent obvious.
      rect_empty = (x0 >= H_LIM) || (y0 >= V_LIM) ||
                   (x0 > xe_clip) || (y0 > ye_clip);
   end

   // ---------------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      xe_d    = xe_q;
      ye_d    = ye_q;
      in_d    = in_q;
      load    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               x0_d = x0;
               y0_d = y0;
               xe_d = xe_clip;
               ye_d = ye_clip;
               if (rect_empty) begin
                  // No writes. The visible address and data outputs keep
                  // their previous values.
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_FILL;
                  h_d     = x0;
                  v_d     = y0;
                  in_d    = color;
               end
            end
         end

         ST_FILL: begin
            if (fb_ready) begin
               load = 1'b1;
               if (h_q == xe_q) begin
                  if (v_q == ye_q) begin
                     // The last pixel is being written. The counter stays at
                     // (xe, ye), so the outputs hold the final address.
                     state_d = ST_DONE;
                  end else begin
                     h_d = x0_q;
                     v_d = v_q + 11'd1;
                  end
               end else begin
                  h_d = h_q + 11'd1;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         h_q     <= 11'd0;
         v_q     <= 11'd0;
         x0_q    <= 11'd0;
         y0_q    <= 11'd0;
         xe_q    <= 11'd0;
         ye_q    <= 11'd0;
         in_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         xe_q    <= xe_d;
         ye_q    <= ye_d;
         in_q    <= in_d;
      end
   end

   assign busy    = (state_q == ST_FILL);
   assign done    = (state_q == ST_DONE);
   assign PIXEL_H = h_q;
   assign PIXEL_V = v_q;
   assign in      = in_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// -----------------------------------------------------------------------------
// tb_fb_rect_fill
//
// Self-checking bench for fb_rect_fill. The reference model lists the expected
// writes of a rectangle directly from the clipping rules, using nested loops.
// It derives the completion cycle from the recorded grant pattern.
// -----------------------------------------------------------------------------
module tb_fb_rect_fill;

   logic        clk;
   logic        reset;
   logic        start;
   logic [10:0] x0, y0, x1, y1;
   logic        color;
   logic        fb_ready;
   logic        busy, done, load, in;
   logic [10:0] PIXEL_H, PIXEL_V;
   logic [1:0]  state_o;

   int checks = 0;
   int errors = 0;

   // Observed and expected writes, packed as {V, H, data}.
   logic [22:0] obs_q[$];
   logic [22:0] exp_q[$];
   bit          rdy_hist[$];
   int          done_cyc, busy_cnt, hold_err, timeout;

   fb_rect_fill dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .x0       (x0),
      .y0       (y0),
      .x1       (x1),
      .y1       (y1),
      .color    (color),
      .fb_ready (fb_ready),
      .busy     (busy),
      .done     (done),
      .PIXEL_H  (PIXEL_H),
      .PIXEL_V  (PIXEL_V),
      .load     (load),
      .in       (in),
      .state_o  (state_o)
   );

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------- reference model
   function automatic void build_model(input int ax0, input int ay0,
                                       input int ax1, input int ay1,
                                       input bit c);
      int xe, ye;
      exp_q.delete();
      xe = (ax1 > 799) ? 799 : ax1;
      ye = (ay1 > 479) ? 479 : ay1;
      if (ax0 >= 800 || ay0 >= 480 || ax0 > xe || ay0 > ye) return;
      for (int v = ay0; v <= ye; v++)
         for (int h = ax0; h <= xe; h++)
            exp_q.push_back({11'(v), 11'(h), c});
   endfunction

   // done appears in the cycle after the grant that carried the last write.
   function automatic int exp_done_cycle(input int writes);
      int n = 0;
      if (writes == 0) return 0;
      foreach (rdy_hist[i]) begin
         if (rdy_hist[i]) begin
            n++;
            if (n == writes) return i + 1;
         end
      end
      return -1;
   endfunction

   // ---------------------------------------------------------------- driver
   // Starts a fill in the next cycle and records the writes until done.
   // Cycle index 0 is the first cycle after the edge that sampled start.
   // rmode: 0 = grant always, 1 = alternating 1/0, 2 = random.
   // mid_start >= 0 pulses a competing start at that cycle index.
   task automatic do_fill(input int ax0, input int ay0, input int ax1,
                          input int ay1, input bit c, input int rmode,
                          input int mid_start);
      int          cyc;
      logic [10:0] ph, pv;
      bit          prev_load;
      @(posedge clk); #1;
      x0 = ax0[10:0]; y0 = ay0[10:0]; x1 = ax1[10:0]; y1 = ay1[10:0];
      color = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      obs_q.delete(); rdy_hist.delete();
      done_cyc = -1; busy_cnt = 0; hold_err = 0; timeout = 0;
      cyc = 0; prev_load = 1'b1; ph = '0; pv = '0;
      forever begin
         case (rmode)
            0:       fb_ready = 1'b1;
            1:       fb_ready = (cyc % 2 == 0);
            default: fb_ready = ($urandom_range(0, 3) != 0);
         endcase
         rdy_hist.push_back(fb_ready);
         if (cyc == mid_start) begin
            start = 1'b1; x0 = 11'd100; y0 = 11'd100;
            x1 = 11'd200; y1 = 11'd200; color = ~c;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (load !== (busy & fb_ready)) hold_err++;
         if (busy && done) hold_err++;
         if (busy && !prev_load && cyc > 0 && (PIXEL_H !== ph || PIXEL_V !== pv))
            hold_err++;
         ph = PIXEL_H; pv = PIXEL_V; prev_load = load;
         if (load) obs_q.push_back({PIXEL_V, PIXEL_H, in});
         if (busy) busy_cnt++;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         cyc++;
         if (cyc > 2000) begin
            timeout = 1;
            break;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   // ----------------------------------------------------------------- tests
   task automatic test_reset();
      reset = 1'b1; start = 1'b0; fb_ready = 1'b0; color = 1'b0;
      x0 = '0; y0 = '0; x1 = '0; y1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, load, in} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctl: busy/done/load/in=%b expected 0000", {busy, done, load, in});
      end
      checks++;
      if (PIXEL_H !== 11'd0 || PIXEL_V !== 11'd0) begin
         errors++;
         $display("FAIL reset_addr: H=%0d V=%0d expected 0 0", PIXEL_H, PIXEL_V);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_single_pixel();
      do_fill(5, 7, 5, 7, 1'b1, 0, -1);
      build_model(5, 7, 5, 7, 1'b1);
      checks++;
      if (timeout != 0 || obs_q.size() != 1) begin
         errors++;
         $display("FAIL single_count: writes=%0d expected 1 (timeout=%0d)", obs_q.size(), timeout);
      end
      checks++;
      if (obs_q.size() > 0 && obs_q[0] !== exp_q[0]) begin
         errors++;
         $display("FAIL single_addr: got %h expected %h", obs_q[0], exp_q[0]);
      end
      checks++;
      if (done_cyc != 1 || busy_cnt != 1) begin
         errors++;
         $display("FAIL single_timing: done_cyc=%0d busy_cycles=%0d expected 1 1", done_cyc, busy_cnt);
      end
   endtask

   task automatic test_clipping();
      do_fill(790, 470, 2000, 2000, 1'b1, 0, -1);
      build_model(790, 470, 2000, 2000, 1'b1);
      checks++;
      if (timeout != 0 || obs_q.size() != 100 || exp_q.size() != 100) begin
         errors++;
         $display("FAIL clip_count: writes=%0d expected 100", obs_q.size());
      end
      foreach (exp_q[i]) begin
         if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL clip_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (done_cyc != 100 || hold_err != 0) begin
         errors++;
         $display("FAIL clip_timing: done_cyc=%0d hold_err=%0d expected 100 0", done_cyc, hold_err);
      end
   endtask

   task automatic test_empty();
      do_fill(10, 10, 5, 20, 1'b1, 0, -1);
      checks++;
      if (obs_q.size() != 0 || done_cyc != 0 || busy_cnt != 0 || hold_err != 0) begin
         errors++;
         $display("FAIL empty_inverted: writes=%0d done_cyc=%0d busy=%0d expected 0 0 0",
                  obs_q.size(), done_cyc, busy_cnt);
      end
      do_fill(800, 0, 900, 10, 1'b0, 0, -1);
      checks++;
      if (obs_q.size() != 0 || done_cyc != 0 || busy_cnt != 0 || hold_err != 0) begin
         errors++;
         $display("FAIL empty_offscreen: writes=%0d done_cyc=%0d busy=%0d expected 0 0 0",
                  obs_q.size(), done_cyc, busy_cnt);
      end
   endtask

   task automatic test_throttle();
      do_fill(0, 0, 3, 1, 1'b1, 1, -1);
      build_model(0, 0, 3, 1, 1'b1);
      checks++;
      if (obs_q.size() != 8 || done_cyc != 15) begin
         errors++;
         $display("FAIL throttle_count: writes=%0d done_cyc=%0d expected 8 15", obs_q.size(), done_cyc);
      end
      foreach (exp_q[i]) begin
         if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL throttle_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (hold_err != 0) begin
         errors++;
         $display("FAIL throttle_hold: hold_err=%0d expected 0", hold_err);
      end
   endtask

   task automatic test_random();
      int rx0, ry0, rx1, ry1, exp_dc;
      bit c;
      for (int t = 0; t < 14; t++) begin
         rx0 = $urandom_range(0, 1) ? $urandom_range(790, 805) : $urandom_range(0, 799);
         ry0 = $urandom_range(0, 1) ? $urandom_range(470, 485) : $urandom_range(0, 479);
         rx1 = rx0 + $urandom_range(0, 9) - 1;
         ry1 = ry0 + $urandom_range(0, 5) - 1;
         if (rx1 < 0) rx1 = 0;
         if (ry1 < 0) ry1 = 0;
         c = 1'($urandom_range(0, 1));
         do_fill(rx0, ry0, rx1, ry1, c, 2, -1);
         build_model(rx0, ry0, rx1, ry1, c);
         exp_dc = exp_done_cycle(exp_q.size());
         checks++;
         if (timeout != 0 || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand%0d_count: rect (%0d,%0d)-(%0d,%0d) writes=%0d expected %0d",
                     t, rx0, ry0, rx1, ry1, obs_q.size(), exp_q.size());
         end
         foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
               checks++;
               if (obs_q[i] !== exp_q[i]) begin
                  errors++;
                  $display("FAIL rand%0d_write[%0d]: got %h expected %h", t, i, obs_q[i], exp_q[i]);
               end
            end
         end
         checks++;
         if (done_cyc != exp_dc || busy_cnt != exp_dc || hold_err != 0) begin
            errors++;
            $display("FAIL rand%0d_timing: done_cyc=%0d busy=%0d hold_err=%0d expected %0d %0d 0",
                     t, done_cyc, busy_cnt, hold_err, exp_dc, exp_dc);
         end
      end
   endtask

   task automatic test_ignored_start();
      do_fill(0, 0, 9, 1, 1'b1, 0, 5);
      build_model(0, 0, 9, 1, 1'b1);
      checks++;
      if (obs_q.size() != 20 || done_cyc != 20) begin
         errors++;
         $display("FAIL ignored_start_count: writes=%0d done_cyc=%0d expected 20 20", obs_q.size(), done_cyc);
      end
      foreach (exp_q[i]) begin
         if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL ignored_start_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      do_fill(20, 30, 22, 30, 1'b1, 0, -1);
      do_fill(40, 50, 41, 51, 1'b0, 0, -1);
      build_model(40, 50, 41, 51, 1'b0);
      checks++;
      if (obs_q.size() != 4 || done_cyc != 4) begin
         errors++;
         $display("FAIL b2b_count: writes=%0d done_cyc=%0d expected 4 4", obs_q.size(), done_cyc);
      end
      foreach (exp_q[i]) begin
         if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL b2b_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_fill();
      int wcount = 0;
      int guard  = 0;
      bit extra  = 1'b0;
      @(posedge clk); #1;
      x0 = 11'd0; y0 = 11'd0; x1 = 11'd9; y1 = 11'd9; color = 1'b1;
      start = 1'b1; fb_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      // The reset is raised in the cycle that presents pixel 50.
      while (guard < 300) begin
         if (wcount == 49) reset = 1'b1;
         @(negedge clk);
         if (load) wcount++;
         if (reset) break;
         guard++;
         @(posedge clk); #1;
      end
      checks++;
      if (wcount != 50) begin
         errors++;
         $display("FAIL reset_mid_written: writes=%0d expected 50", wcount);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({load, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_ctl: load/busy/done=%b expected 000", {load, busy, done});
      end
      checks++;
      if (PIXEL_H !== 11'd0 || PIXEL_V !== 11'd0 || in !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_outputs: H=%0d V=%0d in=%b expected 0 0 0", PIXEL_H, PIXEL_V, in);
      end
      repeat (20) begin
         @(negedge clk);
         if (done || load || busy) extra = 1'b1;
      end
      checks++;
      if (extra) begin
         errors++;
         $display("FAIL reset_mid_aftermath: activity=1 expected 0");
      end
   endtask

   // ------------------------------------------------------------- sequence
   initial begin
      test_reset();
      test_single_pixel();
      test_clipping();
      test_empty();
      test_throttle();
      test_random();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid_fill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
